// File: rtl/unary_sng_pair_pkg.sv
// Shared definitions for the dual-channel stochastic number generator.
//   BWIDTH_DEF : default operand width
//   FRAME_DEF  : default frame length, 2**BWIDTH_DEF bits
//   TAPS_DEF   : Fibonacci feedback mask, x^8+x^6+x^5+x^4+1 (bit i = stage i)
//   SEED_DEF   : LFSR state loaded at every frame start (nonzero)
//   state_t    : generator FSM encoding
package unary_sng_pair_pkg;

  localparam int                      BWIDTH_DEF = 8;
  localparam int                      FRAME_DEF  = 1 << BWIDTH_DEF;
  localparam logic [BWIDTH_DEF-1:0]   TAPS_DEF   = 8'b10111000;
  localparam logic [BWIDTH_DEF-1:0]   SEED_DEF   = 8'h01;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/lfsr_debruijn.sv
// Zero-inserted (de Bruijn) Fibonacci LFSR.
// The extra term in the feedback splices the all-zero state into the maximal
// sequence, so the register walks all 2**BWIDTH states once per period and
// returns to SEED after exactly 2**BWIDTH steps.
// Ports:
//   iClk    clock, posedge
//   iRst    synchronous reset, active-high; loads SEED
//   iLoad   load SEED (priority over iEn)
//   iEn     advance one step
//   oState  current state
module lfsr_debruijn
  import unary_sng_pair_pkg::*;
#(
  parameter int                BWIDTH = BWIDTH_DEF,
  parameter logic [BWIDTH-1:0] TAPS   = TAPS_DEF,
  parameter logic [BWIDTH-1:0] SEED   = SEED_DEF
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iLoad,
  input  logic              iEn,
  output logic [BWIDTH-1:0] oState
);

  logic [BWIDTH-1:0] state_q;
  logic              fb;

  // The zero-detect on the low stages flips the feedback exactly when the
  // register is about to leave or enter the all-zero state.
  always_comb begin
    fb = (^(state_q & TAPS)) ^ (state_q[BWIDTH-2:0] == '0);
  end

  always_ff @(posedge iClk) begin
    if (iRst || iLoad) begin
      state_q <= SEED;
    end else if (iEn) begin
      state_q <= {state_q[BWIDTH-2:0], fb};
    end
  end

  assign oState = state_q;

endmodule

// File: rtl/unary_sng_pair.sv
// Dual-channel stochastic number generator. Converts two unsigned BWIDTH-bit
// operands into unipolar bitstreams, one bit per cycle, 2**BWIDTH bits per
// frame. Each frame is exact: ones(oA) == latched A, ones(oB) == latched B.
// Ports:
//   iClk         clock, posedge
//   iRst         synchronous reset, active-high
//   iValid       operand pair offered
//   oReady       operands accepted this cycle (idle, or last bit of a frame)
//   iA, iB       operands, unipolar values iA/FRAME, iB/FRAME
//   oA, oB       bitstreams, forced 0 when oBitValid is 0
//   oBitValid    oA/oB carry a frame bit
//   oFrameStart  first bit of a frame
//   oFrameEnd    last bit of a frame
module unary_sng_pair
  import unary_sng_pair_pkg::*;
#(
  parameter int                BWIDTH = BWIDTH_DEF,
  parameter logic [BWIDTH-1:0] TAPS   = TAPS_DEF,
  parameter logic [BWIDTH-1:0] SEED   = SEED_DEF
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iValid,
  output logic              oReady,
  input  logic [BWIDTH-1:0] iA,
  input  logic [BWIDTH-1:0] iB,
  output logic              oA,
  output logic              oB,
  output logic              oBitValid,
  output logic              oFrameStart,
  output logic              oFrameEnd
);

  localparam logic [BWIDTH-1:0] LAST = {BWIDTH{1'b1}};

  state_t            state_q, state_d;
  logic [BWIDTH-1:0] count_q;
  logic [BWIDTH-1:0] reg_a_q, reg_b_q;
  logic [BWIDTH-1:0] lfsr_state, lfsr_rev;
  logic              last_bit;
  logic              accept;

  lfsr_debruijn #(
    .BWIDTH (BWIDTH),
    .TAPS   (TAPS),
    .SEED   (SEED)
  ) u_lfsr (
    .iClk   (iClk),
    .iRst   (iRst),
    .iLoad  (accept),
    .iEn    (state_q == RUN),
    .oState (lfsr_state)
  );

  // Channel B compares against the bit-reversed state: still a permutation of
  // all values (so the frame stays exact) but decorrelated from channel A.
  always_comb begin
    lfsr_rev = '0;
    for (int i = 0; i < BWIDTH; i++) begin
      lfsr_rev[i] = lfsr_state[BWIDTH-1-i];
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    last_bit = (state_q == RUN) && (count_q == LAST);
    oReady   = (state_q == IDLE) || last_bit;
    accept   = iValid && oReady;
    state_d  = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (last_bit) state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame counter and operand registers. An accept on the last bit reloads
  // them without a gap; the output stage below still uses the old operands
  // for that final bit.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      count_q <= '0;
      reg_a_q <= '0;
      reg_b_q <= '0;
    end else if (accept) begin
      count_q <= '0;
      reg_a_q <= iA;
      reg_b_q <= iB;
    end else if (state_q == RUN) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Registered outputs; idle cycles drive all-zero so downstream never sees
  // a stray one outside a frame. Reset mid-frame drops the frame silently.
  always_ff @(posedge iClk) begin
    if (iRst || (state_q != RUN)) begin
      oA          <= 1'b0;
      oB          <= 1'b0;
      oBitValid   <= 1'b0;
      oFrameStart <= 1'b0;
      oFrameEnd   <= 1'b0;
    end else begin
      oA          <= (lfsr_state < reg_a_q);
      oB          <= (lfsr_rev < reg_b_q);
      oBitValid   <= 1'b1;
      oFrameStart <= (count_q == '0);
      oFrameEnd   <= last_bit;
    end
  end

endmodule

// File: tb/tb_unary_sng_pair.sv
// Self-checking bench for unary_sng_pair.
module tb_unary_sng_pair;

  localparam int              W     = 8;
  localparam int              N     = 1 << W;
  localparam logic [W-1:0]    TAPS  = 8'b10111000;
  localparam logic [W-1:0]    SEED  = 8'h01;

  logic         iClk = 1'b0;
  logic         iRst;
  logic         iValid;
  logic         oReady;
  logic [W-1:0] iA, iB;
  logic         oA, oB, oBitValid, oFrameStart, oFrameEnd;

  always #5 iClk = ~iClk;

  unary_sng_pair #(
    .BWIDTH (W),
    .TAPS   (TAPS),
    .SEED   (SEED)
  ) dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iValid      (iValid),
    .oReady      (oReady),
    .iA          (iA),
    .iB          (iB),
    .oA          (oA),
    .oB          (oB),
    .oBitValid   (oBitValid),
    .oFrameStart (oFrameStart),
    .oFrameEnd   (oFrameEnd)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame bit k compares the k-th element of the de Bruijn sequence starting
  // at SEED; the sequence itself is built once from the stepping rule.
  logic [W-1:0] seq [N];

  function automatic logic [W-1:0] step_rule(input logic [W-1:0] s);
    logic fb;
    fb = (^(s & TAPS)) ^ (s[W-2:0] == '0);
    return {s[W-2:0], fb};
  endfunction

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  bit           m_active;
  int           m_idx;
  logic [W-1:0] m_a, m_b;
  bit           e_valid, e_a, e_b, e_fs, e_fe;

  // Observed per-frame statistics (from DUT outputs).
  int ones_a, ones_b, nbits, zero_pos_b;
  int last_a, last_b, last_n, last_zero_b;
  int tot_valid, frames_done;

  task automatic step();
    bit rdy;
    rdy = !m_active || (m_idx == N-1);
    check("ready", oReady, rdy);
    @(posedge iClk);
    e_valid = 0; e_a = 0; e_b = 0; e_fs = 0; e_fe = 0;
    if (iRst) begin
      m_active = 0;
    end else begin
      if (m_active) begin
        e_valid = 1;
        e_a     = seq[m_idx] < m_a;
        e_b     = rev(seq[m_idx]) < m_b;
        e_fs    = (m_idx == 0);
        e_fe    = (m_idx == N-1);
      end
      if (iValid && rdy) begin
        m_active = 1; m_idx = 0; m_a = iA; m_b = iB;
      end else if (m_active) begin
        if (m_idx == N-1) m_active = 0;
        else m_idx++;
      end
    end
    #1;
    check("bit_valid", oBitValid, e_valid);
    check("oA", oA, e_a);
    check("oB", oB, e_b);
    check("frame_start", oFrameStart, e_fs);
    check("frame_end", oFrameEnd, e_fe);
    if (oBitValid === 1'b1) begin
      if (oFrameStart === 1'b1) begin
        ones_a = 0; ones_b = 0; nbits = 0; zero_pos_b = -1;
      end
      if (oB === 1'b0) zero_pos_b = nbits;
      ones_a += int'(oA);
      ones_b += int'(oB);
      nbits++;
      tot_valid++;
      if (oFrameEnd === 1'b1) begin
        last_a = ones_a; last_b = ones_b; last_n = nbits; last_zero_b = zero_pos_b;
        frames_done++;
      end
    end
  endtask

  // Accept one pair, then let the full frame drain with iValid low while the
  // operand inputs wander (they must be ignored).
  task automatic run_frame(input logic [W-1:0] a, input logic [W-1:0] b, input bit log_lfsr);
    int seen [N];
    int n_once;
    foreach (seen[i]) seen[i] = 0;
    iValid = 1; iA = a; iB = b;
    step();
    iValid = 0;
    for (int k = 0; k < N; k++) begin
      iA = W'($urandom); iB = W'($urandom);
      if (log_lfsr) seen[int'(dut.u_lfsr.oState)]++;
      step();
    end
    if (log_lfsr) begin
      n_once = 0;
      foreach (seen[i]) if (seen[i] == 1) n_once++;
      check("lfsr_each_once", n_once, N);
      check("lfsr_back_to_seed", dut.u_lfsr.oState, SEED);
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           ones_a;
    int           ones_b;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k255, frames0, tot0;
    logic [W-1:0] ra, rb;

    vecs[0] = '{a: 8'd100, b: 8'd37,  ones_a: 100, ones_b: 37};
    vecs[1] = '{a: 8'd0,   b: 8'd255, ones_a: 0,   ones_b: 255};
    vecs[2] = '{a: 8'd255, b: 8'd0,   ones_a: 255, ones_b: 0};
    vecs[3] = '{a: 8'd1,   b: 8'd254, ones_a: 1,   ones_b: 254};
    vecs[4] = '{a: 8'd128, b: 8'd128, ones_a: 128, ones_b: 128};

    seq[0] = SEED;
    for (int i = 1; i < N; i++) seq[i] = step_rule(seq[i-1]);
    k255 = -1;
    for (int i = 0; i < N; i++) if (rev(seq[i]) == 8'hFF) k255 = i;

    ones_a = 0; ones_b = 0; nbits = 0; zero_pos_b = -1;
    last_a = -1; last_b = -1; last_n = -1; last_zero_b = -1;
    tot_valid = 0; frames_done = 0;
    m_active = 0; m_idx = 0; m_a = '0; m_b = '0;

    // Reset state.
    iRst = 1; iValid = 0; iA = '0; iB = '0;
    repeat (3) @(posedge iClk);
    #1;
    check("rst_ready", oReady, 1);
    check("rst_bit_valid", oBitValid, 0);
    check("rst_oA", oA, 0);
    check("rst_oB", oB, 0);
    check("rst_frame_start", oFrameStart, 0);
    check("rst_frame_end", oFrameEnd, 0);
    iRst = 0;

    // Table of single frames; the first also logs the LFSR walk.
    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].a, vecs[v].b, v == 0);
      check("frame_ones_a", last_a, vecs[v].ones_a);
      check("frame_ones_b", last_b, vecs[v].ones_b);
      check("frame_bits", last_n, N);
      if (v == 1) check("oB_zero_position", last_zero_b, k255);
    end

    // Back-to-back frames with iValid held high.
    tot0 = tot_valid;
    iValid = 1; iA = 8'd10; iB = 8'd200;
    step();
    iA = 8'd20; iB = 8'd7;
    repeat (N) step();
    check("b2b_ones_10", last_a, 10);
    check("b2b_ones_b_200", last_b, 200);
    iA = 8'd30; iB = 8'd99;
    repeat (N) step();
    check("b2b_ones_20", last_a, 20);
    iValid = 0;
    repeat (N) step();
    check("b2b_ones_30", last_a, 30);
    check("b2b_ones_b_99", last_b, 99);
    check("b2b_valid_bits", tot_valid - tot0, 3 * N);
    step();
    check("b2b_idle_after", oBitValid, 0);

    // Offer while mid-frame: must be ignored.
    iValid = 1; iA = 8'd90; iB = 8'd60;
    step();
    iValid = 0;
    repeat (50) step();
    iValid = 1; iA = 8'd200; iB = 8'd5;
    check("midframe_not_ready", oReady, 0);
    step();
    iValid = 0;
    repeat (N - 51) step();
    check("midframe_ones_a", last_a, 90);
    check("midframe_ones_b", last_b, 60);
    check("midframe_bits", last_n, N);

    // Reset at count 120 aborts the frame without a frame end.
    iValid = 1; iA = 8'd77; iB = 8'd150;
    step();
    iValid = 0;
    repeat (120) step();
    frames0 = frames_done;
    iRst = 1;
    step();
    iRst = 0;
    check("abort_bit_valid", oBitValid, 0);
    check("abort_ready", oReady, 1);
    check("abort_no_frame_end", frames_done, frames0);
    run_frame(8'd77, 8'd150, 1'b0);
    check("after_abort_ones_a", last_a, 77);
    check("after_abort_ones_b", last_b, 150);
    check("after_abort_bits", last_n, N);

    // Random operand pairs.
    repeat (4) begin
      ra = W'($urandom_range(0, N-1));
      rb = W'($urandom_range(0, N-1));
      run_frame(ra, rb, 1'b0);
      check("rand_ones_a", last_a, int'(ra));
      check("rand_ones_b", last_b, int'(rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
